// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter driving ps2_clk/ps2_data open-drain through *_oe outputs.
// Optional macro PS2_TX_RETRY_EN: one automatic retry after the first NACK or timeout.
module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYCLES = 3000,
  parameter int unsigned TIMEOUT_CYCLES = 375000,
  parameter int unsigned FILTER_LEN     = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_err,
  output logic       busy
);

  localparam int unsigned MaxCnt = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES
                                                                      : TIMEOUT_CYCLES;
  localparam int unsigned TimerW = $clog2(MaxCnt + 1);
  localparam int unsigned FiltW  = $clog2(FILTER_LEN + 1);

  typedef enum logic [2:0] {StIdle, StInhibit, StReq, StStart, StAcked, StNack} state_e;

  logic             clk_s1, clk_s2, dat_s1, dat_s2;
  logic             clk_filt;
  logic [FiltW-1:0] filt_cnt;
  logic             fall;

  state_e            state_q, state_d;
  logic [TimerW-1:0] timer_q, timer_d;
  logic [3:0]        fall_cnt_q, fall_cnt_d;
  logic [7:0]        data_q, data_d;
  logic              done_q, done_d, err_q, err_d;
  logic              fail;
  logic [2:0]        bit_idx;

  // Synchronisers and glitch filter; the filtered clock flips on the FILTER_LEN-th differing sample.
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_s1   <= 1'b1;
      clk_s2   <= 1'b1;
      dat_s1   <= 1'b1;
      dat_s2   <= 1'b1;
      clk_filt <= 1'b1;
      filt_cnt <= '0;
    end else begin
      clk_s1 <= ps2_clk_i;
      clk_s2 <= clk_s1;
      dat_s1 <= ps2_data_i;
      dat_s2 <= dat_s1;
      if (clk_s2 == clk_filt) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FiltW'(FILTER_LEN - 1)) begin
        clk_filt <= clk_s2;
        filt_cnt <= '0;
      end else begin
        filt_cnt <= filt_cnt + 1'b1;
      end
    end
  end

  assign fall = clk_filt & ~clk_s2 & (filt_cnt == FiltW'(FILTER_LEN - 1));

`ifdef PS2_TX_RETRY_EN
  logic retry_q, retry_d;
  always_ff @(posedge clk) begin
    if (reset) retry_q <= 1'b0;
    else       retry_q <= retry_d;
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      timer_q    <= '0;
      fall_cnt_q <= '0;
      data_q     <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      fall_cnt_q <= fall_cnt_d;
      data_q     <= data_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    fall_cnt_d = fall_cnt_q;
    data_d     = data_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    fail       = 1'b0;
`ifdef PS2_TX_RETRY_EN
    retry_d    = retry_q;
`endif
    if (state_q != StIdle) timer_d = timer_q + 1'b1;
    unique case (state_q)
      StIdle: begin
        if (tx_valid) begin
          data_d     = tx_data;
          state_d    = StInhibit;
          timer_d    = '0;
          fall_cnt_d = '0;
`ifdef PS2_TX_RETRY_EN
          retry_d    = 1'b0;
`endif
        end
      end
      StInhibit: if (timer_q == TimerW'(INHIBIT_CYCLES - 1)) state_d = StReq;
      StReq: begin
        state_d = StStart;
        timer_d = '0;
      end
      StStart: begin
        if (fall && fall_cnt_q != 4'd11) begin
          fall_cnt_d = fall_cnt_q + 4'd1;
          if (fall_cnt_q == 4'd10) state_d = dat_s2 ? StNack : StAcked;
        end
      end
      StAcked: begin
        if (clk_s2 && dat_s2) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      StNack:  fail    = 1'b1;
      default: state_d = StIdle;
    endcase

    // Timeout takes priority over a simultaneous ACK completion.
    if ((state_q == StStart || state_q == StAcked || state_q == StNack) &&
        timer_q == TimerW'(TIMEOUT_CYCLES - 1)) begin
      fail = 1'b1;
    end

    if (fail) begin
      done_d = 1'b0;
`ifdef PS2_TX_RETRY_EN
      if (!retry_q) begin
        retry_d    = 1'b1;
        state_d    = StInhibit;
        timer_d    = '0;
        fall_cnt_d = '0;
      end else begin
        state_d = StIdle;
        err_d   = 1'b1;
      end
`else
      state_d = StIdle;
      err_d   = 1'b1;
`endif
    end
  end

  // After fall k (1..8) the line carries data bit k-1; fall_cnt 8 wraps bit_idx to 7.
  assign bit_idx = fall_cnt_q[2:0] - 3'd1;

  always_comb begin
    ps2_clk_oe  = 1'b0;
    ps2_data_oe = 1'b0;
    unique case (state_q)
      StInhibit: ps2_clk_oe = 1'b1;
      StReq: begin
        ps2_clk_oe  = 1'b1;
        ps2_data_oe = 1'b1;
      end
      StStart: begin
        if (fall_cnt_q == 4'd0)      ps2_data_oe = 1'b1;
        else if (fall_cnt_q <= 4'd8) ps2_data_oe = ~data_q[bit_idx];
        else if (fall_cnt_q == 4'd9) ps2_data_oe = ^data_q;
        else                         ps2_data_oe = 1'b0;
      end
      default: ;
    endcase
  end

  assign tx_ready = (state_q == StIdle);
  assign busy     = (state_q != StIdle);
  assign tx_done  = done_q;
  assign tx_err   = err_q;

endmodule
